// File: rtl/inst_fetch_if.sv
// Fetch-side bundle between the control FSM / ROM / IR and the fetch controller.
// master = fetch controller, slave = control FSM plus ROM/IR pair.
interface inst_fetch_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic              Fetch;
    logic              PC_ld;
    logic [ADDR_W-1:0] PC_in;
    logic [ADDR_W-1:0] Inst_addr;
    logic              Inst_rd;
    logic [DATA_W-1:0] Inst;
    logic              Id;
    logic              Done;
    logic              Busy;
    logic [ADDR_W-1:0] PC;

    modport master (
        input  Fetch, PC_ld, PC_in, Inst,
        output Inst_addr, Inst_rd, Id, Done, Busy, PC
    );

    modport slave (
        output Fetch, PC_ld, PC_in, Inst,
        input  Inst_addr, Inst_rd, Id, Done, Busy, PC
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch controller: owns the PC, reads ROM, strobes IR load.
// Latency: Fetch at edge N -> Inst_rd N+1, Id N+2, Done N+3; one fetch per 3 cycles.
// Backpressure: while Busy, Fetch and PC_ld are dropped (no pending latch).
module inst_fetch #(
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          Clk,
    input  logic          Reset_n,
    inst_fetch_if.master  fetch_if
);

    // Catch a mismatched interface instance at elaboration time.
    if ($bits(fetch_if.Inst) != DATA_W || $bits(fetch_if.PC) != ADDR_W) begin : g_width_chk
        $error("inst_fetch: interface widths do not match ADDR_W/DATA_W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // IDLE and DONE are the only states that accept new requests; a PC_ld
    // arriving with Fetch lands in pc_q on the same edge the read is launched.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_if.PC_ld) pc_d = fetch_if.PC_in;
                if (fetch_if.Fetch) state_d = READ;
            end
            READ: begin
                state_d = LOAD;
            end
            LOAD: begin
                state_d = DONE;
                pc_d    = pc_q + 1'b1;
            end
            DONE: begin
                if (fetch_if.PC_ld) pc_d = fetch_if.PC_in;
                state_d = fetch_if.Fetch ? READ : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fetch_if.Inst_rd   = (state_q == READ);
    assign fetch_if.Id        = (state_q == LOAD);
    assign fetch_if.Done      = (state_q == DONE);
    assign fetch_if.Busy      = (state_q == READ) || (state_q == LOAD);
    assign fetch_if.PC        = pc_q;
    assign fetch_if.Inst_addr = pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboarded bench for inst_fetch: driver models accepted fetches, monitor checks timing/data.
module tb_inst_fetch;
    localparam int AW = 7;
    localparam int DW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            e;      // edge at which Fetch was accepted
    } txn_t;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    inst_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    inst_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .fetch_if (bus)
    );

    logic [DW-1:0] rom [0:(1<<AW)-1];
    logic [DW-1:0] ir;
    int            ecnt = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    bit            mon_en = 0;

    txn_t          q[$];
    int            free_edge = 0;
    logic [AW-1:0] m_pc = '0;

    // Synchronous ROM and the IR it feeds.
    always @(posedge Clk) begin
        ecnt <= ecnt + 1;
        if (bus.Inst_rd) bus.Inst <= rom[bus.Inst_addr];
        if (bus.Id) ir <= bus.Inst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // Driver + reference model: a fetch is accepted only when at least 3 edges
    // have passed since the previous accepted one.
    task automatic step(input bit f, input bit l, input logic [AW-1:0] pin);
        int e;
        @(negedge Clk);
        #1;
        bus.Fetch = f;
        bus.PC_ld = l;
        bus.PC_in = pin;
        e = ecnt + 1;
        if (Reset_n && e >= free_edge) begin
            if (l) m_pc = pin;
            if (f) begin
                q.push_back('{addr: m_pc, data: rom[m_pc], e: e});
                m_pc      = m_pc + 1'b1;
                free_edge = e + 3;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0);
    endtask

    // Monitor: every cycle compare strobes and PC against the head transaction.
    always @(negedge Clk) begin
        if (mon_en && Reset_n) begin
            bit            exp_rd, exp_id, exp_done;
            logic [AW-1:0] exp_pc;
            exp_rd = 0; exp_id = 0; exp_done = 0;
            exp_pc = m_pc;
            if (q.size() > 0) begin
                exp_rd   = (ecnt == q[0].e);
                exp_id   = (ecnt == q[0].e + 1);
                exp_done = (ecnt == q[0].e + 2);
                exp_pc   = (ecnt < q[0].e + 2) ? q[0].addr : q[0].addr + 1'b1;
            end
            chk("inst_rd", {31'd0, bus.Inst_rd}, {31'd0, exp_rd});
            chk("id",      {31'd0, bus.Id},      {31'd0, exp_id});
            chk("done",    {31'd0, bus.Done},    {31'd0, exp_done});
            chk("busy",    {31'd0, bus.Busy},    {31'd0, exp_rd | exp_id});
            chk("pc",      {25'd0, bus.PC},      {25'd0, exp_pc});
            chk("inst_addr_eq_pc", {25'd0, bus.Inst_addr}, {25'd0, bus.PC});
            if (exp_rd) chk("rd_addr", {25'd0, bus.Inst_addr}, {25'd0, q[0].addr});
            if (exp_id) chk("inst_data", {16'd0, bus.Inst}, {16'd0, q[0].data});
            if (exp_done) begin
                chk("ir", {16'd0, ir}, {16'd0, q[0].data});
                void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [DW-1:0] ir_saved;
        for (int i = 0; i < (1 << AW); i++) rom[i] = DW'(i * 16'h0101) ^ 16'h0F0F;
        rom[0] = 16'h2010; rom[1] = 16'h3520; rom[2] = 16'h1111; rom[3] = 16'h2222;
        rom[5] = 16'h5555; rom[127] = 16'hABCD;
        bus.Fetch = 0; bus.PC_ld = 0; bus.PC_in = '0; bus.Inst = '0;
        ir = '0;

        // Reset state
        repeat (3) @(posedge Clk);
        #2;
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_id",   {31'd0, bus.Id},   32'd0);
        chk("rst_pc",   {25'd0, bus.PC},   32'd0);
        @(negedge Clk);
        #1;
        Reset_n = 1;
        mon_en  = 1;

        // 1: single fetch from 0
        step(1, 0, '0); idle(5);
        chk("t1_ir", {16'd0, ir}, 32'h2010);
        // 2: Fetch held 9 cycles from PC=1
        for (int i = 0; i < 9; i++) step(1, 0, '0);
        idle(3);
        chk("t2_pc", {25'd0, bus.PC}, 32'd4);
        chk("t2_ir", {16'd0, ir}, 32'h2222);
        // 3: jump to 127 with fetch, wrap
        step(1, 1, 7'h7F); idle(4);
        chk("t3_pc", {25'd0, bus.PC}, 32'd0);
        chk("t3_ir", {16'd0, ir}, 32'hABCD);
        // 4: PC_ld during READ ignored, later honoured in IDLE
        step(1, 0, '0); step(0, 1, 7'd5); idle(4);
        chk("t4_pc", {25'd0, bus.PC}, 32'd1);
        step(1, 1, 7'd5); idle(4);
        chk("t4_ir", {16'd0, ir}, 32'h5555);
        // 6: Fetch only during READ/LOAD adds nothing
        step(1, 0, '0); step(1, 0, '0); step(1, 0, '0); step(0, 0, '0); idle(4);
        chk("t6_qempty", q.size(), 32'd0);

        // 5: reset in the middle of LOAD
        step(1, 0, '0); step(0, 0, '0);
        @(posedge Clk);
        #2;
        chk("t5_id_before", {31'd0, bus.Id}, 32'd1);
        ir_saved = ir;
        mon_en  = 0;
        Reset_n = 0;
        #1;
        chk("t5_id_async",   {31'd0, bus.Id},      32'd0);
        chk("t5_busy_async", {31'd0, bus.Busy},    32'd0);
        chk("t5_rd_async",   {31'd0, bus.Inst_rd}, 32'd0);
        chk("t5_pc_async",   {25'd0, bus.PC},      32'd0);
        chk("t5_addr_async", {25'd0, bus.Inst_addr}, 32'd0);
        q.delete();
        m_pc = '0;
        free_edge = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        #1;
        Reset_n = 1;
        mon_en  = 1;
        idle(2);
        chk("t5_ir_kept", {16'd0, ir}, {16'd0, ir_saved});
        step(1, 0, '0); idle(4);
        chk("t5_ir_after", {16'd0, ir}, 32'h2010);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, AW'($urandom));
        idle(5);
        chk("final_qempty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
